afe_chain_block: RTL
====================

AFE_CHAIN_BLOCK -- requirements
Module: afe_chain_block

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of ADC channels (1..16).
REQ-002 SHALL have parameter BITS_ADC, default 12, ADC sample width.
REQ-003 SHALL have parameter REC_LEN, default 12, record-control register width per channel.
REQ-004 SHALL have parameter CH_SLOT, default 8, chain cycles per channel slot (>=2).
REQ-005 SHALL have parameters SPI_ADDR_LEN 10, SPI_DATA_LEN 16, SPI_CODE_LEN 6; CA = max(1, clog2(N_CH)) channel address bits.
REQ-006 SHALL have clk  input  1  single system clock, all logic rising-edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have code / addr / data_in  input  SPI_CODE_LEN / SPI_ADDR_LEN / SPI_DATA_LEN  decoded SPI command.
REQ-009 SHALL have reg_map_addr  input  SPI_ADDR_LEN-CA  block base address.
REQ-010 SHALL have data_out  inout  SPI_DATA_LEN  read data, high-Z when not selected.
REQ-011 SHALL have adc_ready  input  1  asynchronous, rising edge = new samples.
REQ-012 SHALL have data_from_adc  input  N_CH*BITS_ADC  channel k at bits [k*BITS_ADC +: BITS_ADC].
REQ-013 SHALL have data_from_pre / data_to_post  input / output  BITS_ADC+1  daisy-chain in/out; MSB 0 = valid sample.
REQ-014 SHALL have rec  output  N_CH*REC_LEN, samp_rate_mux  output  2, d_hp  output  4, frame_busy  output  1.

Function
REQ-015 SHALL treat the command as selected (sel) when addr[SPI_ADDR_LEN-1:CA]==reg_map_addr; ch = addr[CA-1:0].
REQ-016 SHALL register code/addr/data_in once; a command executes once, on the first registered cycle it is present (edge of match vs previous registered cycle), i.e. 2 clk edges after presentation; a held command never re-executes.
REQ-017 SHALL implement writes: code 4 & sel -> rec[ch] <= data_in[REC_LEN-1:0]; code 7 -> MSB of every rec cleared; code 8 -> MSB of every rec set; code 14 -> samp_rate_mux <= data_in[1:0]; code 5 & sel -> d_hp <= data_in[3:0]; code 20 & sel -> ch_en <= data_in[N_CH-1:0]; code 21 & sel -> overrun cleared.
REQ-018 SHALL ignore code 4 / read a value of 0 when ch >= N_CH.
REQ-019 SHALL implement reads (sel): code 1 -> {rec[ch], d_hp}; code 15 -> samp_rate_mux; code 19 -> adc_buf[ch] zero-extended; code 22 -> {frame_busy, overrun, ch_en} LSB-aligned; other codes -> 0; fields truncated to SPI_DATA_LEN.
REQ-020 SHALL drive data_out from the 2nd clk edge after a read command is presented until 1 edge after it is removed; high-Z otherwise.
REQ-021 SHALL synchronise adc_ready through 2 flops plus an edge register; on the detected edge, capture all channels into adc_buf and start a frame (cnt <= 0, frame_busy <= 1).
REQ-022 SHALL run cnt 0..N_CH*CH_SLOT-1 while frame_busy; frame_busy clears on the cycle after cnt reaches the last value.
REQ-023 SHALL in a frame set data_to_post <= {1'b0, adc_buf[k]} when cnt==k*CH_SLOT and ch_en[k]=1, else data_to_post <= data_from_pre (one-cycle register).
REQ-024 SHALL hold data_to_post all-ones when not frame_busy.
REQ-025 SHALL, on an adc_ready edge while frame_busy, set sticky overrun, recapture adc_buf, and restart cnt at 0.
REQ-026 SHALL let a code 21 clear coinciding with an overrun event leave overrun set.

Reset
REQ-027 SHALL on rst_n low set every rec to 12'h07E (LSBs if REC_LEN differs), samp_rate_mux 2'b11, d_hp 4'hF, ch_en all ones, adc_buf all ones, overrun 0, frame_busy 0, cnt 0, data_to_post all ones, data_out high-Z.
REQ-028 SHALL on reset asserted mid-frame abort immediately; after release, no frame until a new adc_ready edge.

Verification
REQ-029 SHALL verify: N_CH=4, adc_ready rise with samples 0x111/0x222/0x333/0x444 -> data_to_post 0x0111, 0x0222, 0x0333, 0x0444 at cnt 0/8/16/24, forwarded pre data elsewhere, all ones after cnt 31.
REQ-030 SHALL verify: code 4, addr {base,2'd2}, data 0x0ABC held 10 cycles -> rec[2]=0xABC after 2 edges, single update; code 1 same addr -> data_out 0xABCF.
REQ-031 SHALL verify: code 7 then code 8 -> all rec MSBs 0 then 1, other bits unchanged.
REQ-032 SHALL verify: ch_en=4'b1010 -> slots 0 and 2 forward data_from_pre, slots 1 and 3 insert samples.
REQ-033 SHALL verify: second adc_ready edge at cnt 12 -> overrun=1, frame restarts at cnt 0; code 22 reads bit N_CH = 1; code 21 clears it.
REQ-034 SHALL verify: rst_n low at cnt 5 -> all reset values, frame_busy 0, data_to_post 0x1FFF, data_out high-Z.

Source files
------------

// File: rtl/afe_chain_block_if.sv
// Purpose: decoded SPI command bus (code / address / write data) into the AFE chain block.
// Latency: none, plain wires; the consumer registers every field once.
// Backpressure: none; a command is simply held until the master removes it.
// Ports: master drives code, addr, data_in; slave samples them.
interface afe_chain_block_if #(
  parameter int SPI_ADDR_LEN = 10,
  parameter int SPI_DATA_LEN = 16,
  parameter int SPI_CODE_LEN = 6
);
  logic [SPI_CODE_LEN-1:0] code;
  logic [SPI_ADDR_LEN-1:0] addr;
  logic [SPI_DATA_LEN-1:0] data_in;

  modport master (output code, addr, data_in);
  modport slave  (input  code, addr, data_in);
endinterface

// File: rtl/afe_chain_block.sv
// Purpose: per-channel record/control registers plus ADC sample insertion into a daisy chain.
// Latency: commands act 2 edges after presentation; samples reach the chain 4 edges after adc_ready rises.
// Backpressure: none; a new adc_ready edge mid-frame flags overrun and restarts the frame.
// Ports: clk/rst_n, cmd (SPI command bus), reg_map_addr, data_out (tri-state read bus),
//        adc_ready/data_from_adc (sample strobe/data), data_from_pre/data_to_post (chain),
//        rec/samp_rate_mux/d_hp (control outputs), frame_busy.
module afe_chain_block #(
  parameter int N_CH         = 4,
  parameter int BITS_ADC     = 12,
  parameter int REC_LEN      = 12,
  parameter int CH_SLOT      = 8,
  parameter int SPI_ADDR_LEN = 10,
  parameter int SPI_DATA_LEN = 16,
  parameter int SPI_CODE_LEN = 6,
  localparam int CA          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  afe_chain_block_if.slave             cmd,
  input  logic [SPI_ADDR_LEN-CA-1:0]   reg_map_addr,
  inout  wire  [SPI_DATA_LEN-1:0]      data_out,
  input  logic                         adc_ready,
  input  logic [N_CH*BITS_ADC-1:0]     data_from_adc,
  input  logic [BITS_ADC:0]            data_from_pre,
  output logic [BITS_ADC:0]            data_to_post,
  output logic [N_CH*REC_LEN-1:0]      rec,
  output logic [1:0]                   samp_rate_mux,
  output logic [3:0]                   d_hp,
  output logic                         frame_busy
);
  localparam int FRAME_LEN = N_CH * CH_SLOT;
  localparam int CW        = $clog2(FRAME_LEN);

  logic [SPI_CODE_LEN-1:0] code_q, code_p;
  logic [SPI_ADDR_LEN-1:0] addr_q, addr_p;
  logic [SPI_DATA_LEN-1:0] data_q, data_p;
  logic [N_CH-1:0]          ch_en;
  logic                     overrun;
  logic [N_CH*BITS_ADC-1:0] adc_buf;
  logic [CW-1:0]            cnt;
  logic [2:0]               adc_s;
  logic                     oe_q;
  logic [SPI_DATA_LEN-1:0]  rdata_q, rdata_c;
  logic [REC_LEN-1:0]       rec_sel;
  logic [BITS_ADC-1:0]      buf_sel;

  // Only the four read codes drive the shared bus; writes leave it released.
  function automatic logic is_rd(input logic [SPI_CODE_LEN-1:0] c);
    return (c == SPI_CODE_LEN'(1))  || (c == SPI_CODE_LEN'(15)) ||
           (c == SPI_CODE_LEN'(19)) || (c == SPI_CODE_LEN'(22));
  endfunction

  wire [CA-1:0] ch_q    = addr_q[CA-1:0];
  wire          sel_q   = (addr_q[SPI_ADDR_LEN-1:CA] == reg_map_addr);
  wire          sel_raw = (cmd.addr[SPI_ADDR_LEN-1:CA] == reg_map_addr);
  wire          ch_ok   = (32'(ch_q) < N_CH);
  // A command executes only on the cycle its registered copy first differs from
  // the previous one, so holding it on the bus never repeats the action.
  wire          exec    = ({code_q, addr_q, data_q} != {code_p, addr_p, data_p});
  // Second sync flop high while the edge register is still low.
  wire          adc_edge = adc_s[1] & ~adc_s[2];

  always_comb begin
    rec_sel = '0;
    buf_sel = '0;
    if (ch_ok) begin
      rec_sel = rec[int'(ch_q)*REC_LEN +: REC_LEN];
      buf_sel = adc_buf[int'(ch_q)*BITS_ADC +: BITS_ADC];
    end
  end

  always_comb begin
    rdata_c = '0;
    case (code_q)
      SPI_CODE_LEN'(1):  if (ch_ok) rdata_c = SPI_DATA_LEN'({rec_sel, d_hp});
      SPI_CODE_LEN'(15): rdata_c = SPI_DATA_LEN'(samp_rate_mux);
      SPI_CODE_LEN'(19): if (ch_ok) rdata_c = SPI_DATA_LEN'(buf_sel);
      SPI_CODE_LEN'(22): rdata_c = SPI_DATA_LEN'({frame_busy, overrun, ch_en});
      default:           rdata_c = '0;
    endcase
  end

  assign data_out = oe_q ? rdata_q : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      code_p        <= '0;
      addr_p        <= '0;
      data_p        <= '0;
      rec           <= {N_CH{REC_LEN'(12'h07E)}};
      samp_rate_mux <= 2'b11;
      d_hp          <= 4'hF;
      ch_en         <= '1;
      adc_buf       <= '1;
      overrun       <= 1'b0;
      frame_busy    <= 1'b0;
      cnt           <= '0;
      data_to_post  <= '1;
      adc_s         <= '0;
      oe_q          <= 1'b0;
      rdata_q       <= '0;
    end else begin
      code_q <= cmd.code;
      addr_q <= cmd.addr;
      data_q <= cmd.data_in;
      code_p <= code_q;
      addr_p <= addr_q;
      data_p <= data_q;
      adc_s  <= {adc_s[1:0], adc_ready};

      // Enable needs the read both registered and still on the bus: turns on at
      // the second edge, drops on the first edge after removal.
      oe_q    <= is_rd(code_q) & sel_q & is_rd(cmd.code) & sel_raw;
      rdata_q <= rdata_c;

      if (exec) begin
        case (code_q)
          SPI_CODE_LEN'(4):  if (sel_q && ch_ok) rec[int'(ch_q)*REC_LEN +: REC_LEN] <= data_q[REC_LEN-1:0];
          SPI_CODE_LEN'(7):  for (int k = 0; k < N_CH; k++) rec[k*REC_LEN + REC_LEN-1] <= 1'b0;
          SPI_CODE_LEN'(8):  for (int k = 0; k < N_CH; k++) rec[k*REC_LEN + REC_LEN-1] <= 1'b1;
          SPI_CODE_LEN'(14): samp_rate_mux <= data_q[1:0];
          SPI_CODE_LEN'(5):  if (sel_q) d_hp <= data_q[3:0];
          SPI_CODE_LEN'(20): if (sel_q) ch_en <= data_q[N_CH-1:0];
          SPI_CODE_LEN'(21): if (sel_q) overrun <= 1'b0;
          default: ;
        endcase
      end

      // Placed after the command decode so a coinciding overrun wins over a clear.
      if (adc_edge) begin
        adc_buf    <= data_from_adc;
        cnt        <= '0;
        frame_busy <= 1'b1;
        if (frame_busy) overrun <= 1'b1;
      end else if (frame_busy) begin
        if (cnt == CW'(FRAME_LEN-1)) begin
          frame_busy <= 1'b0;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (!frame_busy) begin
        data_to_post <= '1;
      end else begin
        data_to_post <= data_from_pre;
        for (int k = 0; k < N_CH; k++)
          if (ch_en[k] && (cnt == CW'(k*CH_SLOT)))
            data_to_post <= {1'b0, adc_buf[k*BITS_ADC +: BITS_ADC]};
      end
    end
  end
endmodule
